// File: rtl/mux_scan_seq.sv
// mux_scan_seq
//   Registered N-channel multiplexer that time-shares one datapath across
//   many input channels. In manual mode the channel comes from sel_in; in
//   auto-scan mode an internal sequencer walks the channels enabled in
//   ch_mask, holding each one for DWELL cycles and wrapping back to the
//   lowest enabled channel after the highest.
//
// Ports
//   clk        clock, everything updates on the rising edge
//   rst_n      synchronous reset, active low, overrides all other inputs
//   en         block enable, 0 parks the block in IDLE
//   mode       0 = manual select, 1 = auto-scan
//   sel_in     manual channel select
//   ch_mask    auto-scan channel enables, bit i = channel i
//   d          packed channel data, channel i = d[i*DW +: DW]
//   out        registered selected data
//   out_ch     index of the channel currently shown on out
//   out_valid  out/out_ch carry meaningful data
//   wrap       one-cycle pulse when the scan returns to a lower/equal index
module mux_scan_seq #(
    parameter int N_CH  = 16,
    parameter int DW    = 1,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic [N_CH-1:0]      ch_mask,
    input  logic [N_CH*DW-1:0]   d,
    output logic [DW-1:0]        out,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    output logic                 wrap
);

    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

    state_t            state;
    logic [SEL_W-1:0]  cur_ch;
    logic [CW-1:0]     dwell_cnt;
    logic              starved;
    logic              wrap_pend;

    logic [SEL_W-1:0]  entry_ch;
    logic [SEL_W-1:0]  eff_ch;
    logic [CW-1:0]     eff_cnt;
    logic              eff_last;
    logic              above_found;
    logic [SEL_W-1:0]  above_ch;
    logic [SEL_W-1:0]  next_ch;
    logic [DW-1:0]     man_data;
    logic [DW-1:0]     scan_data;
    logic              sel_ok;

    // Channel arithmetic for the sequencer. While starved (mask was empty)
    // the first nonzero mask is treated as a fresh start at its lowest set
    // bit, so the effective channel/count stand in for cur_ch/dwell_cnt.
    always_comb begin
        entry_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) entry_ch = SEL_W'(i);
        end

        eff_ch   = starved ? entry_ch : cur_ch;
        eff_cnt  = starved ? '0 : dwell_cnt;
        eff_last = (eff_cnt == CW'(DWELL - 1));

        above_found = 1'b0;
        above_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i] && (i > int'(eff_ch))) begin
                above_found = 1'b1;
                above_ch    = SEL_W'(i);
            end
        end
        next_ch = above_found ? above_ch : entry_ch;

        man_data  = '0;
        scan_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_in == SEL_W'(i)) man_data  = d[i*DW +: DW];
            if (eff_ch == SEL_W'(i)) scan_data = d[i*DW +: DW];
        end
        sel_ok = (int'(sel_in) < N_CH);
    end

    // Control FSM and output registers. wrap_pend remembers that the last
    // dwell expiry wrapped, so the wrap pulse lines up with the edge where
    // the wrapped channel first reaches out_ch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_ch    <= '0;
            dwell_cnt <= '0;
            starved   <= 1'b0;
            wrap_pend <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    wrap      <= 1'b0;
                    if (mode) begin
                        state     <= SCAN;
                        cur_ch    <= entry_ch;
                        dwell_cnt <= '0;
                        starved   <= (ch_mask == '0);
                        wrap_pend <= 1'b0;
                    end else begin
                        state <= MAN;
                    end
                end
                MAN: begin
                    out       <= sel_ok ? man_data : '0;
                    out_ch    <= sel_in;
                    out_valid <= sel_ok;
                    wrap      <= 1'b0;
                    if (mode) begin
                        state     <= SCAN;
                        cur_ch    <= entry_ch;
                        dwell_cnt <= '0;
                        starved   <= (ch_mask == '0);
                        wrap_pend <= 1'b0;
                    end
                end
                SCAN: begin
                    if (ch_mask == '0) begin
                        out_valid <= 1'b0;
                        wrap      <= 1'b0;
                        cur_ch    <= '0;
                        dwell_cnt <= '0;
                        starved   <= 1'b1;
                        wrap_pend <= 1'b0;
                    end else begin
                        out       <= scan_data;
                        out_ch    <= eff_ch;
                        out_valid <= 1'b1;
                        wrap      <= wrap_pend;
                        starved   <= 1'b0;
                        wrap_pend <= eff_last && !above_found;
                        if (eff_last) begin
                            dwell_cnt <= '0;
                            cur_ch    <= next_ch;
                        end else begin
                            dwell_cnt <= eff_cnt + CW'(1);
                            cur_ch    <= eff_ch;
                        end
                    end
                    if (!mode) state <= MAN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
